ascii_sum_tx: RTL

//   Output end of the ASCII adder datapath. Accepts one binary sum word per handshake,

---
 rtl/ascii_sum_tx.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/ascii_sum_tx.sv
// ascii_sum_tx: converts a binary sum to decimal (double dabble) and streams it as ASCII digits.
// Optional build macro CRLF_EN appends 8'h0D, 8'h0A after the digits.
module ascii_sum_tx #(
    parameter int SUM_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sum_valid,
    output logic             sum_ready,
    input  logic [SUM_W-1:0] sum_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [7:0]       tx_data,
    output logic             tx_last,
    output logic             busy
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(SUM_W + 1);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(SUM_W);

    function automatic longint pow10(input int n);
        longint p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    if (pow10(DIGITS) <= ((longint'(1) << SUM_W) - 1)) begin : g_digits_check
        $error("ascii_sum_tx: DIGITS too small to hold the largest SUM_W value");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONVERT,
        S_SEND
    } state_t;

    state_t             r_state;
    logic [SUM_W-1:0]   r_bin;
    logic [BCD_W-1:0]   r_bcd;
    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_digIdx;
    logic               r_sumReady;
    logic               r_txValid;
    logic [7:0]         r_txData;
    logic               r_txLast;
    logic               r_busy;
`ifdef CRLF_EN
    logic               r_term;
`endif

    logic [BCD_W-1:0]   w_bcdAdj;
    logic [IDX_W-1:0]   w_firstIdx;
    logic [3:0]         w_firstDigit;
    logic [IDX_W-1:0]   w_nextIdx;
    logic [3:0]         w_nextDigit;

    always_comb begin
        w_bcdAdj = r_bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) w_bcdAdj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
    end

    // Highest non-zero digit starts the number; an all-zero value falls back to digit 0.
    always_comb begin
        w_firstIdx   = '0;
        w_firstDigit = r_bcd[3:0];
        for (int i = 0; i < DIGITS; i++) begin
            if (r_bcd[4*i +: 4] != 4'd0) begin
                w_firstIdx   = IDX_W'(i);
                w_firstDigit = r_bcd[4*i +: 4];
            end
        end
    end

    always_comb begin
        w_nextIdx   = r_digIdx - IDX_W'(1);
        w_nextDigit = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (IDX_W'(i) == w_nextIdx) w_nextDigit = r_bcd[4*i +: 4];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_bin      <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_digIdx   <= '0;
            r_sumReady <= 1'b0;
            r_txValid  <= 1'b0;
            r_txData   <= 8'h00;
            r_txLast   <= 1'b0;
            r_busy     <= 1'b0;
`ifdef CRLF_EN
            r_term     <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_sumReady <= 1'b1;
                    if (sum_valid && r_sumReady) begin
                        r_sumReady <= 1'b0;
                        r_busy     <= 1'b1;
                        r_bin      <= sum_data;
                        r_bcd      <= '0;
                        r_cnt      <= '0;
                        r_state    <= S_CONVERT;
                    end
                end
                S_CONVERT: begin
                    if (r_cnt == CNT_DONE) begin
                        r_txValid <= 1'b1;
                        r_txData  <= 8'h30 + {4'h0, w_firstDigit};
                        r_digIdx  <= w_firstIdx;
`ifdef CRLF_EN
                        r_txLast  <= 1'b0;
                        r_term    <= 1'b0;
`else
                        r_txLast  <= (w_firstIdx == '0);
`endif
                        r_state   <= S_SEND;
                    end else begin
                        {r_bcd, r_bin} <= {w_bcdAdj[BCD_W-2:0], r_bin, 1'b0};
                        r_cnt          <= r_cnt + CNT_W'(1);
                    end
                end
                S_SEND: begin
                    if (tx_ready) begin
                        if (r_txLast) begin
                            r_txValid  <= 1'b0;
                            r_txLast   <= 1'b0;
                            r_txData   <= 8'h00;
                            r_busy     <= 1'b0;
                            r_sumReady <= 1'b1;
                            r_state    <= S_IDLE;
`ifdef CRLF_EN
                        end else if (r_term) begin
                            r_txData <= 8'h0A;
                            r_txLast <= 1'b1;
                        end else if (r_digIdx == '0) begin
                            r_txData <= 8'h0D;
                            r_term   <= 1'b1;
                        end else begin
                            r_txData <= 8'h30 + {4'h0, w_nextDigit};
                            r_digIdx <= w_nextIdx;
                        end
`else
                        end else begin
                            r_txData <= 8'h30 + {4'h0, w_nextDigit};
                            r_digIdx <= w_nextIdx;
                            r_txLast <= (w_nextIdx == '0);
                        end
`endif
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign sum_ready = r_sumReady;
    assign tx_valid  = r_txValid;
    assign tx_data   = r_txData;
    assign tx_last   = r_txLast;
    assign busy      = r_busy;

endmodule
